// File: rtl/arb_request_queue_if.sv
// Handshake bundle for arb_request_queue: per-requester push side and the single
// arbitrated output port. master = traffic source/sink, slave = the queue itself.
interface arb_request_queue_if #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH     = 32
);
  localparam int unsigned IdW = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0]            in_valid;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQUESTERS-1:0]            in_ready;
  logic                                 out_valid;
  logic [DATA_WIDTH-1:0]                out_data;
  logic [IdW-1:0]                       out_id;
  logic                                 out_ready;
  logic [NUM_REQUESTERS-1:0]            grant_oh;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_id, grant_oh
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_id, grant_oh
  );
endinterface

// File: rtl/arb_request_queue.sv
// Per-requester FIFOs feeding a round-robin arbiter onto one valid/ready port.
// Define ARB_QUEUE_STATS_EN to add the xfer_count / drop_count statistics outputs.
module arb_request_queue #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  arb_request_queue_if.slave bus
`ifdef ARB_QUEUE_STATS_EN
  ,
  output logic [31:0]        xfer_count,
  output logic [15:0]        drop_count
`endif
);
  localparam int unsigned N    = NUM_REQUESTERS;
  localparam int unsigned IdW  = $clog2(N);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH-1:0] mem_q  [N][FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q [N];
  logic [PtrW-1:0]       wptr_d [N];
  logic [PtrW-1:0]       rptr_q [N];
  logic [PtrW-1:0]       rptr_d [N];
  logic [CntW-1:0]       cnt_q  [N];
  logic [CntW-1:0]       cnt_d  [N];
  logic [N-1:0]          prio_q, prio_d;
  logic [N-1:0]          req, grant, push, pop, full;
  logic [IdW-1:0]        gidx;
  logic                  xfer;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      full[i] = (cnt_q[i] == CntW'(FIFO_DEPTH));
      req[i]  = (cnt_q[i] != '0);
      push[i] = bus.in_valid[i] & ~full[i];
    end
  end

  // Round-robin scan: first pending requester at or above the priority bit, wrapping.
  always_comb begin
    int unsigned pidx;
    int unsigned idx;
    logic        found;
    grant = '0;
    gidx  = '0;
    pidx  = 0;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (prio_q[i]) pidx = i;
    end
    for (int unsigned k = 0; k < N; k++) begin
      idx = (pidx + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = IdW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant[i]) bus.out_data = mem_q[i][rptr_q[i]];
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = |req;
  assign bus.out_id    = gidx;
  assign bus.grant_oh  = grant;
  assign xfer          = (|req) & bus.out_ready;
  assign pop           = grant & {N{xfer}};

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      wptr_d[i] = wptr_q[i] + PtrW'(push[i]);
      rptr_d[i] = rptr_q[i] + PtrW'(pop[i]);
      cnt_d[i]  = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
    end
    prio_d = xfer ? {grant[N-2:0], grant[N-1]} : prio_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      prio_q <= N'(1);
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      prio_q <= prio_d;
    end
  end

  // Storage needs no reset: contents are only observable through a non-zero count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef ARB_QUEUE_STATS_EN
  logic [31:0] xfer_count_q;
  logic [15:0] drop_count_q;
  logic        drop;

  assign drop = |(bus.in_valid & full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      if (xfer) xfer_count_q <= xfer_count_q + 32'd1;
      if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign xfer_count = xfer_count_q;
  assign drop_count = drop_count_q;
`endif
endmodule

// File: tb/tb_arb_request_queue.sv
// Directed bench for arb_request_queue: stimulus pushes expected transfers into a
// scoreboard queue, a negedge monitor pops and compares every accepted output beat.
module tb_arb_request_queue;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned D  = 4;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_request_queue_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) bus ();

`ifdef ARB_QUEUE_STATS_EN
  logic [31:0] xfer_count;
  logic [15:0] drop_count;
`endif

  arb_request_queue #(
    .NUM_REQUESTERS(N),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef ARB_QUEUE_STATS_EN
    ,
    .xfer_count(xfer_count),
    .drop_count(drop_count)
`endif
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL xfer_unexpected: got id %0d data 0x%0h, expected no transfer",
                 bus.out_id, bus.out_data);
      end else begin
        e = sb.pop_front();
        check("xfer_id", 32'(bus.out_id), 32'(e.id));
        check("xfer_data", bus.out_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic load(input int i, input logic [DW-1:0] d);
    bus.in_valid[i]        = 1'b1;
    bus.in_data[i*DW +: DW] = d;
  endtask

  task automatic commit();
    step();
    bus.in_valid = '0;
  endtask

  task automatic expect_x(input int id, input logic [DW-1:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step();
    step();

    // Reset state
    at_neg();
    check("rst_in_ready", 32'(bus.in_ready), 32'hF);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_grant", 32'(bus.grant_oh), 32'h0);
    check("rst_out_id", 32'(bus.out_id), 32'h0);
    check("rst_out_data", bus.out_data, 32'h0);
    step();
    rst = 1'b0;

    // 1: single push, one-cycle latency
    load(2, 32'hA0);
    expect_x(2, 32'hA0);
    commit();
    at_neg();
    check("t1_valid", 32'(bus.out_valid), 32'h1);
    check("t1_id", 32'(bus.out_id), 32'h2);
    check("t1_data", bus.out_data, 32'hA0);
    check("t1_grant", 32'(bus.grant_oh), 32'h4);
    step();
    bus.out_ready = 1'b1;
    at_neg();
    step();
    bus.out_ready = 1'b0;
    at_neg();
    check("t1_empty", 32'(bus.out_valid), 32'h0);

    // 2: one packet per requester, round-robin from requester 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(i, 32'h10 + 32'(i));
      expect_x(i, 32'h10 + 32'(i));
    end
    commit();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check("t2_seq_id", 32'(bus.out_id), 32'(k));
      step();
    end
    bus.out_ready = 1'b0;
    at_neg();
    check("t2_empty", 32'(bus.out_valid), 32'h0);

    // 3: requesters 0 and 2 backlogged -> grants alternate
    for (int k = 0; k < 3; k++) begin
      load(0, 32'h20 + 32'(k));
      load(2, 32'h40 + 32'(k));
      expect_x(0, 32'h20 + 32'(k));
      expect_x(2, 32'h40 + 32'(k));
      commit();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      check("t3_grant", 32'(bus.grant_oh), (k % 2 == 0) ? 32'h1 : 32'h4);
      step();
    end
    bus.out_ready = 1'b0;
    at_neg();
    check("t3_empty", 32'(bus.out_valid), 32'h0);

    // 4: stall holds grant and data, then requester 1 then 3
    do_reset();
    load(1, 32'h51);
    load(3, 32'h53);
    expect_x(1, 32'h51);
    expect_x(3, 32'h53);
    commit();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("t4_hold_grant", 32'(bus.grant_oh), 32'h2);
      check("t4_hold_data", bus.out_data, 32'h51);
      step();
    end
    bus.out_ready = 1'b1;
    at_neg();
    step();
    at_neg();
    check("t4_next_grant", 32'(bus.grant_oh), 32'h8);
    step();
    bus.out_ready = 1'b0;
    at_neg();
    check("t4_empty", 32'(bus.out_valid), 32'h0);

    // 5: fill requester 0, drop a fifth push, drain in order
    do_reset();
    for (int k = 0; k < 4; k++) begin
      load(0, 32'h60 + 32'(k));
      expect_x(0, 32'h60 + 32'(k));
      commit();
      at_neg();
      check("t5_in_ready0", 32'(bus.in_ready[0]), (k < 3) ? 32'h1 : 32'h0);
    end
    load(0, 32'h64);
    commit();
    at_neg();
    check("t5_full_ready", 32'(bus.in_ready), 32'hE);
    check("t5_head_data", bus.out_data, 32'h60);
`ifdef ARB_QUEUE_STATS_EN
    check("t5_drop_count", 32'(drop_count), 32'h1);
`endif
    step();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      step();
    end
    bus.out_ready = 1'b0;
    at_neg();
    check("t5_empty", 32'(bus.out_valid), 32'h0);
`ifdef ARB_QUEUE_STATS_EN
    check("t5_xfer_count", xfer_count, 32'h4);
`endif

    // 6: async reset with packets queued; priority returns to requester 0
    step();
    for (int i = 0; i < 4; i++) load(i, 32'h70 + 32'(i));
    expect_x(1, 32'h71);
    commit();
    bus.out_ready = 1'b1;
    at_neg();
    step();
    bus.out_ready = 1'b0;
    at_neg();
    check("t6_pre_valid", 32'(bus.out_valid), 32'h1);
    check("t6_pre_grant", 32'(bus.grant_oh), 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 32'h0);
    check("t6_rst_ready", 32'(bus.in_ready), 32'hF);
    check("t6_rst_grant", 32'(bus.grant_oh), 32'h0);
    check("t6_rst_data", bus.out_data, 32'h0);
    step();
    step();
    rst = 1'b0;
    load(3, 32'h83);
    load(0, 32'h80);
    expect_x(0, 32'h80);
    expect_x(3, 32'h83);
    commit();
    at_neg();
    check("t6_post_grant", 32'(bus.grant_oh), 32'h1);
    step();
    bus.out_ready = 1'b1;
    at_neg();
    step();
    at_neg();
    step();
    bus.out_ready = 1'b0;
    at_neg();
    check("t6_empty", 32'(bus.out_valid), 32'h0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
